// File: rtl/xy_moment_window.sv
// Sliding-window m00 / m10 / m01 intensity moments over a WINDOW_SIZE_X x WINDOW_SIZE_Y window, one column per cycle.
// Latency: column sampled at edge N is visible on the outputs after edge N+2, i.e. three cycles after it is presented.
// Backpressure: none; a column is accepted on every cycle in_valid is high, bubbles pass through as out_valid = 0.
module xy_moment_window #(
  parameter int LUMA_BITS     = 8,
  parameter int WINDOW_SIZE_X = 7,
  parameter int WINDOW_SIZE_Y = 5,
  localparam int HX       = WINDOW_SIZE_X / 2,
  localparam int HY       = WINDOW_SIZE_Y / 2,
  localparam int M00_BITS = LUMA_BITS + $clog2(WINDOW_SIZE_X * WINDOW_SIZE_Y),
  localparam int M01_BITS = $clog2(HY * (HY + 1) * WINDOW_SIZE_X / 2) + LUMA_BITS + 1,
  localparam int M10_BITS = $clog2(HX * (HX + 1) * WINDOW_SIZE_Y / 2) + LUMA_BITS + 1
) (
  input  logic                                      clk,
  input  logic                                      in_reset_n,
  input  logic                                      in_restart,
  input  logic                                      in_valid,
  input  logic [WINDOW_SIZE_Y-1:0][LUMA_BITS-1:0]   in_column,
  input  logic [WINDOW_SIZE_Y-1:0][LUMA_BITS-1:0]   in_peek_column,
  output logic [M00_BITS-1:0]                       out_m00,
  output logic signed [M10_BITS-1:0]                out_m10,
  output logic signed [M01_BITS-1:0]                out_m01,
  output logic                                      out_valid
);

  localparam int SB = LUMA_BITS + $clog2(WINDOW_SIZE_Y);  // column sum width
  localparam int FW = $clog2(WINDOW_SIZE_X + 1);          // fill counter width
  localparam int SW = M00_BITS + 1;
  localparam int XW = M10_BITS + 1;
  localparam int YW = M01_BITS + 1;

  typedef logic [WINDOW_SIZE_Y-1:0][LUMA_BITS-1:0] col_t;

  function automatic logic [SB-1:0] col_sum(input col_t c);
    logic [SB-1:0] acc;
    acc = '0;
    for (int i = 0; i < WINDOW_SIZE_Y; i++) acc = acc + SB'(c[i]);
    return acc;
  endfunction

  // Row weight runs from -HY (top, index 0) to +HY (bottom).
  function automatic logic signed [M01_BITS-1:0] col_wsum(input col_t c);
    logic signed [M01_BITS-1:0] acc, wt, px;
    acc = '0;
    for (int i = 0; i < WINDOW_SIZE_Y; i++) begin
      wt  = M01_BITS'(i - HY);
      px  = M01_BITS'(c[i]);
      acc = acc + wt * px;
    end
    return acc;
  endfunction

  logic                        clear;
  logic [FW-1:0]               fill;
  logic                        filling;
  logic                        v1, full1, v2;
  logic [SB-1:0]               s_in1, s_out1;
  logic signed [M01_BITS-1:0]  w_in1, w_out1;
  logic [M00_BITS-1:0]         acc_s;
  logic signed [M10_BITS-1:0]  acc_mx;
  logic signed [M01_BITS-1:0]  acc_my;
  logic [SW-1:0]               s_nxt;
  logic signed [XW-1:0]        mx_nxt;
  logic signed [YW-1:0]        my_nxt;

  assign clear   = !in_reset_n || in_restart;
  // Until the window has seen WINDOW_SIZE_X columns nothing leaves it, so the peek column is ignored.
  assign filling = fill < FW'(WINDOW_SIZE_X);

  // Stage 1: column sums and y-weighted sums of the entering and leaving columns, plus fill tracking.
  always_ff @(posedge clk) begin
    if (clear) begin
      v1     <= 1'b0;
      full1  <= 1'b0;
      fill   <= '0;
      s_in1  <= '0;
      s_out1 <= '0;
      w_in1  <= '0;
      w_out1 <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        s_in1  <= col_sum(in_column);
        w_in1  <= col_wsum(in_column);
        s_out1 <= filling ? '0 : col_sum(in_peek_column);
        w_out1 <= filling ? '0 : col_wsum(in_peek_column);
        // Window is full once this column is in: fill was already at least WINDOW_SIZE_X-1.
        full1  <= fill >= FW'(WINDOW_SIZE_X - 1);
        if (filling) fill <= fill + 1'b1;
      end
    end
  end

  // Stage 2 arithmetic: shifting the window left moves every column one x step down, so MX loses S;
  // the leaving column is now at -(HX+1) and is added back out, the entering one lands at +HX.
  always_comb begin
    s_nxt  = SW'(acc_s) - SW'(s_out1) + SW'(s_in1);
    mx_nxt = {acc_mx[M10_BITS-1], acc_mx} + XW'(HX + 1) * XW'(s_out1) - XW'(acc_s)
             + XW'(HX) * XW'(s_in1);
    my_nxt = {acc_my[M01_BITS-1], acc_my} - {w_out1[M01_BITS-1], w_out1}
             + {w_in1[M01_BITS-1], w_in1};
  end

  // Stage 2: accumulator update on valid stage-1 data; flags results that describe a full window.
  always_ff @(posedge clk) begin
    if (clear) begin
      acc_s  <= '0;
      acc_mx <= '0;
      acc_my <= '0;
      v2     <= 1'b0;
    end else begin
      v2 <= v1 && full1;
      if (v1) begin
        acc_s  <= M00_BITS'(s_nxt);
        acc_mx <= M10_BITS'(mx_nxt);
        acc_my <= M01_BITS'(my_nxt);
      end
    end
  end

  // Stage 3: publish full-window results; outputs hold between pulses.
  always_ff @(posedge clk) begin
    if (clear) begin
      out_m00   <= '0;
      out_m10   <= '0;
      out_m01   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        out_m00 <= acc_s;
        out_m10 <= acc_mx;
        out_m01 <= acc_my;
      end
    end
  end

endmodule

// File: tb/tb_xy_moment_window.sv
// Randomised and directed bench for xy_moment_window with a scoreboard and a direct-sum window model.
// Expected results are queued at drive time; a negedge monitor pops them whenever out_valid is high.
// Input is never stalled; the bench inserts bubbles, resets and restarts itself.
module tb_xy_moment_window;

  localparam int L    = 8;
  localparam int WX   = 7;
  localparam int WY   = 5;
  localparam int HX   = WX / 2;
  localparam int HY   = WY / 2;
  localparam int M00B = L + $clog2(WX * WY);
  localparam int M01B = $clog2(HY * (HY + 1) * WX / 2) + L + 1;
  localparam int M10B = $clog2(HX * (HX + 1) * WY / 2) + L + 1;

  typedef logic [WY-1:0][L-1:0] col_t;
  typedef struct {
    int m00;
    int m10;
    int m01;
    int cyc;
  } exp_t;

  logic                    clk;
  logic                    in_reset_n;
  logic                    in_restart;
  logic                    in_valid;
  col_t                    in_column;
  col_t                    in_peek_column;
  logic [M00B-1:0]         out_m00;
  logic signed [M10B-1:0]  out_m10;
  logic signed [M01B-1:0]  out_m01;
  logic                    out_valid;

  xy_moment_window #(.LUMA_BITS(L), .WINDOW_SIZE_X(WX), .WINDOW_SIZE_Y(WY)) dut (
    .clk            (clk),
    .in_reset_n     (in_reset_n),
    .in_restart     (in_restart),
    .in_valid       (in_valid),
    .in_column      (in_column),
    .in_peek_column (in_peek_column),
    .out_m00        (out_m00),
    .out_m10        (out_m10),
    .out_m01        (out_m01),
    .out_valid      (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  col_t hist[$];     // every column accepted since the last reset/restart
  exp_t exp_q[$];    // scoreboard
  exp_t obs[$];      // outputs seen in the current phase
  int vectors = 0;
  int checks = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic col_t rand_col();
    col_t c;
    for (int i = 0; i < WY; i++) c[i] = L'($urandom);
    return c;
  endfunction

  // Direct definition: newest column at x = +HX, older ones step left; row i at y = i - HY.
  function automatic exp_t model_window();
    exp_t e;
    int   n;
    e.m00 = 0; e.m10 = 0; e.m01 = 0; e.cyc = 0;
    n = hist.size();
    for (int k = 0; k < WX; k++) begin
      col_t c;
      c = hist[n - 1 - k];
      for (int i = 0; i < WY; i++) begin
        int p;
        p = int'(c[i]);
        e.m00 += p;
        e.m10 += (HX - k) * p;
        e.m01 += (i - HY) * p;
      end
    end
    return e;
  endfunction

  task automatic drive(input bit v, input col_t c, input bit rst, input bit rs);
    exp_t e;
    @(negedge clk);
    #1;
    in_valid   = v;
    in_column  = c;
    in_reset_n = !rst;
    in_restart = rs;
    if (v && hist.size() >= WX) in_peek_column = hist[hist.size() - WX];
    else                        in_peek_column = rand_col();
    vectors++;
    if (rst || rs) begin
      hist.delete();
      exp_q.delete();
    end else if (v) begin
      hist.push_back(c);
      if (hist.size() >= WX) begin
        e     = model_window();
        e.cyc = cyc;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, rand_col(), 1'b0, 1'b0);
  endtask

  // Run bubbles until the scoreboard empties, then confirm the outputs hold the last result.
  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() > 0 && b < 20) begin
      idle(1);
      b++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout_pending", exp_q.size(), 0);
      exp_q.delete();
    end
    idle(2);
    if (obs.size() > 0) begin
      chk("hold_valid", int'(out_valid), 0);
      chk("hold_m00", int'(out_m00), obs[obs.size()-1].m00);
      chk("hold_m10", int'(out_m10), obs[obs.size()-1].m10);
      chk("hold_m01", int'(out_m01), obs[obs.size()-1].m01);
    end
  endtask

  task automatic do_reset(input bit use_restart);
    drive(1'b1, rand_col(), !use_restart, use_restart);
    @(posedge clk);
    #1;
    chk("clr_valid", int'(out_valid), 0);
    chk("clr_m00", int'(out_m00), 0);
    chk("clr_m10", int'(out_m10), 0);
    chk("clr_m01", int'(out_m01), 0);
    obs.delete();
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation, three cycles after its column.
  always @(negedge clk) begin : monitor
    exp_t e;
    exp_t o;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("m00", int'(out_m00), e.m00);
        chk("m10", int'(out_m10), e.m10);
        chk("m01", int'(out_m01), e.m01);
        chk("latency", cyc - e.cyc, 3);
        o.m00 = int'(out_m00);
        o.m10 = int'(out_m10);
        o.m01 = int'(out_m01);
        o.cyc = cyc;
        obs.push_back(o);
      end
    end
  end

  initial begin
    col_t c;
    col_t cols[16];
    in_reset_n     = 1'b0;
    in_restart     = 1'b0;
    in_valid       = 1'b0;
    in_column      = '0;
    in_peek_column = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_m00", int'(out_m00), 0);
    chk("rst_m10", int'(out_m10), 0);
    chk("rst_m01", int'(out_m01), 0);

    // Single pixel travelling across the window and then leaving it.
    c = '0;
    c[0] = 8'h10;
    drive(1'b1, c, 1'b0, 1'b0);
    repeat (7) drive(1'b1, '0, 1'b0, 1'b0);
    drain();
    chk("pixel_pulses", obs.size(), 2);
    if (obs.size() >= 2) begin
      chk("pixel_m00_full", obs[0].m00, 16);
      chk("pixel_m10_full", obs[0].m10, -48);
      chk("pixel_m01_full", obs[0].m01, -32);
      chk("pixel_m00_gone", obs[1].m00, 0);
      chk("pixel_m10_gone", obs[1].m10, 0);
      chk("pixel_m01_gone", obs[1].m01, 0);
    end

    // Flat white image.
    do_reset(1'b0);
    c = '1;
    repeat (10) drive(1'b1, c, 1'b0, 1'b0);
    drain();
    chk("white_pulses", obs.size(), 4);
    foreach (obs[i]) begin
      chk("white_m00", obs[i].m00, 8925);
      chk("white_m10", obs[i].m10, 0);
      chk("white_m01", obs[i].m01, 0);
    end

    // Top two rows white: largest negative m01.
    do_reset(1'b1);
    c = '0;
    c[0] = 8'hff;
    c[1] = 8'hff;
    repeat (7) drive(1'b1, c, 1'b0, 1'b0);
    drain();
    chk("top_pulses", obs.size(), 1);
    if (obs.size() >= 1) begin
      chk("top_m00", obs[0].m00, 3570);
      chk("top_m10", obs[0].m10, 0);
      chk("top_m01", obs[0].m01, -5355);
    end

    // Bubbles before columns 3, 7 and 11 must not disturb the window.
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) cols[i] = rand_col();
    for (int i = 0; i < 16; i++) begin
      if (i == 3 || i == 7 || i == 11) idle(1);
      drive(1'b1, cols[i], 1'b0, 1'b0);
    end
    drain();
    chk("gap_pulses", obs.size(), 10);

    // Reset then restart mid-stream: in-flight columns vanish, a fresh fill is required.
    for (int r = 0; r < 2; r++) begin
      do_reset(1'b0);
      repeat (9) drive(1'b1, rand_col(), 1'b0, 1'b0);
      do_reset(r == 1);
      repeat (6) drive(1'b1, rand_col(), 1'b0, 1'b0);
      idle(5);
      chk("refill_no_early_out", obs.size(), 0);
      drive(1'b1, rand_col(), 1'b0, 1'b0);
      drain();
      chk("refill_pulses", obs.size(), 1);
    end

    // Random image with random bubbles.
    do_reset(1'b1);
    for (int i = 0; i < 200; i++)
      drive($urandom_range(0, 3) != 0, rand_col(), 1'b0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
